// File: rtl/sram_1p_host_pkg.sv
// Shared types and helpers for the single-port SRAM host adapter.
// Response control bits and the write-mask group consistency check live here.
package sram_1p_host_pkg;

  localparam int unsigned MaskMaxW = 1024;

  typedef struct packed {
    logic write;
    logic err;
  } rsp_ctl_t;

  // True when every group of group_w mask bits is uniformly set or clear.
  function automatic logic mask_groups_ok(input logic [MaskMaxW-1:0] mask,
                                          input int unsigned width,
                                          input int unsigned group_w);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < width; i++) begin
      if (mask[i] != mask[(i / group_w) * group_w]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/sram_1p_host_rsp_fifo.sv
// Registered first-in first-out buffer for adapter responses.
// Head entry reads as all-zero while the buffer is empty.
module sram_1p_host_rsp_fifo #(
  parameter int unsigned Depth = 3,
  parameter type T = logic,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  T                wdata_i,
  input  logic            pop_i,
  output T                rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] cnt_o
);

  T                mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  always_comb begin
    do_push  = push_i && (cnt_q != CntW'(Depth));
    do_pop   = pop_i && (cnt_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // Pointers wrap explicitly so Depth need not be a power of two.
    if (do_push) wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign cnt_o   = cnt_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/sram_1p_host_adapter.sv
// Host-side front end for a 1-cycle-latency single-port SRAM: request decode,
// RAM strobes, one-deep issue stage and a bounded in-order response buffer.
module sram_1p_host_adapter
  import sram_1p_host_pkg::*;
#(
  parameter int unsigned Width           = 32,
  parameter int unsigned Depth           = 128,
  parameter int unsigned DataBitsPerMask = 1,
  parameter int unsigned RspDepth        = 3,
  localparam int unsigned Aw = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_write_i,
  input  logic [Aw-1:0]    req_addr_i,
  input  logic [Width-1:0] req_wdata_i,
  input  logic [Width-1:0] req_wmask_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [Width-1:0] rsp_rdata_o,
  output logic             rsp_write_o,
  output logic             rsp_err_o,
  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  output logic [Width-1:0] ram_wmask_o,
  input  logic [Width-1:0] ram_rdata_i
);

  localparam int unsigned CntW = $clog2(RspDepth + 1);

  typedef struct packed {
    logic [Width-1:0] rdata;
    rsp_ctl_t         ctl;
  } rsp_t;

  logic            inflight_q, inflight_d;
  rsp_ctl_t        issue_q, issue_d;
  logic            addr_err, mask_err, req_err, accept, ram_go;
  logic [CntW:0]   occupancy;
  logic [CntW-1:0] fifo_cnt;
  logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
  rsp_t            push_rsp, head_rsp;

  always_comb begin
    addr_err  = 32'(req_addr_i) >= Depth;
    mask_err  = req_write_i && !mask_groups_ok(MaskMaxW'(req_wmask_i), Width, DataBitsPerMask);
    req_err   = addr_err || mask_err;
    // Slots already promised: buffered responses plus the one in the issue stage.
    occupancy = {1'b0, fifo_cnt} + (CntW + 1)'(inflight_q);
    req_ready_o = occupancy < (CntW + 1)'(RspDepth);
    accept    = req_valid_i && req_ready_o;
    ram_go    = accept && !req_err;

    ram_req_o   = ram_go;
    ram_write_o = ram_go && req_write_i;
    ram_addr_o  = ram_go ? req_addr_i  : '0;
    ram_wdata_o = ram_go ? req_wdata_i : '0;
    ram_wmask_o = ram_go ? req_wmask_i : '0;

    inflight_d    = accept;
    issue_d.write = req_write_i;
    issue_d.err   = req_err;

    // RAM read data is only meaningful one cycle after a legal read strobe.
    push_rsp.rdata = (!issue_q.write && !issue_q.err) ? ram_rdata_i : '0;
    push_rsp.ctl   = issue_q;
    fifo_push      = inflight_q && !fifo_full;
    fifo_pop       = !fifo_empty && rsp_ready_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= 1'b0;
      issue_q    <= '0;
    end else begin
      inflight_q <= inflight_d;
      issue_q    <= issue_d;
    end
  end

  sram_1p_host_rsp_fifo #(
    .Depth (RspDepth),
    .T     (rsp_t)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .wdata_i (push_rsp),
    .pop_i   (fifo_pop),
    .rdata_o (head_rsp),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .cnt_o   (fifo_cnt)
  );

  assign rsp_valid_o = !fifo_empty;
  assign rsp_rdata_o = head_rsp.rdata;
  assign rsp_write_o = head_rsp.ctl.write;
  assign rsp_err_o   = head_rsp.ctl.err;

endmodule
